cr_tlvp_ib_arb: RTL and testbench
=================================

Name: cr_tlvp_ib_arb

Overview:
- Frame-granular weighted round-robin arbiter that merges two AXI4-S datapath sources into the single TLVP input-buffer FIFO. That FIFO feeds the TLV parser input decoder.
- Grants one source for a whole frame (first beat through tlast) so the TLV/frame structure seen by the decoder is never interleaved.
- Provides per-source frame counters and a framing-violation pulse.

Parameters:
- CNT_W, 32, width of the per-source frame counters.
- WEIGHT_W, 4, width of the per-source weight (max consecutive frames).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- src0_empty  input  1  source 0 FIFO empty.
- src0_ib  input  axi4s_dp_bus_t  source 0 head-of-FIFO beat.
- src0_rd  output  1  source 0 FIFO pop.
- src1_empty  input  1  source 1 FIFO empty.
- src1_ib  input  axi4s_dp_bus_t  source 1 head-of-FIFO beat.
- src1_rd  output  1  source 1 FIFO pop.
- arb_ob_afull  input  1  TLVP input FIFO almost-full; has at least 2 entries of slack.
- arb_ob_wr  output  1  write strobe to the TLVP input FIFO.
- arb_ob  output  axi4s_dp_bus_t  beat written.
- arb_ob_src  output  1  source index of the beat written.
- cfg_en  input  2  per-source enable.
- cfg_weight0  input  WEIGHT_W  source 0 weight.
- cfg_weight1  input  WEIGHT_W  source 1 weight.
- frame_cnt0  output  CNT_W  frames forwarded from source 0.
- frame_cnt1  output  CNT_W  frames forwarded from source 1.
- arb_error  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, FSM in ARB, last_src=1, credit=0, counters 0. Reset mid-frame abandons the frame; no recovery beats are sent.
- FSM states: ARB and GRANT.
- ARB, candidate set: source s is a candidate when cfg_en[s] & ~srcS_empty.
- ARB, selection:
  - Both candidates and credit>0: keep last_src.
  - Both candidates and credit==0: switch to ~last_src.
  - Single candidate: select it.
  - No candidate: stay in ARB.
- ARB, on selection: go to GRANT(sel).
  - If sel==last_src, credit <= credit-1.
  - Otherwise credit <= weight(sel)-1, last_src <= sel.
  - A weight of 0 is treated as 1.
  - The decision takes one cycle; no pop happens in ARB.
- GRANT(s): srcS_rd = ~srcS_empty & ~arb_ob_afull (combinational). The other source's rd is 0.
- GRANT exit: on a pop of a beat with tlast=1, return to ARB next cycle.
- Mid-frame changes: cfg_en and weight changes are ignored mid-frame and take effect at the next ARB.
- Output pipeline, one cycle latency:
  - arb_ob_wr <= srcS_rd.
  - arb_ob <= popped beat, unmodified.
  - arb_ob_src <= s.
  - When no pop, arb_ob holds its previous value.
- Framing check: first_beat flag is set on entry to GRANT and cleared on the first pop. arb_error pulses one cycle after a pop in either case:
  - tuser[0]=1 with first_beat=0 (sot mid-frame);
  - tuser[0]=0 with first_beat=1 (missing sot).
  - The beat is still forwarded.
- Frame counters: frame_cntS increments one cycle after a tlast pop from S. Counters saturate at all-ones; no wrap.
- Simultaneous events: tlast pop and a newly non-empty other source in the same cycle are resolved in the next ARB cycle, which makes the one-cycle bubble between frames mandatory.
- Empty mid-frame: the arbiter waits in GRANT indefinitely and never switches source.
- Single-beat frame (sot and tlast on the same beat): one pop, then back to ARB.

Test Plan:
- Only src0 enabled, 3-beat frame (tuser 01,00,10; tlast on beat 3) -> arb_ob_wr high for 3 cycles starting 1 cycle after the first src0_rd; arb_ob_src=0; frame_cnt0=1; arb_error=0.
- Both sources continuously backlogged with 1-beat frames, weight0=2, weight1=1 -> grant sequence 0,0,1,0,0,1; after 6 frames frame_cnt0=4, frame_cnt1=2.
- arb_ob_afull asserted during beat 2 of a 4-beat src1 frame for 5 cycles -> src1_rd low for those 5 cycles; no src0 pop; the frame completes contiguously after afull drops.
- Beat with tuser[0]=1 at beat 2 of a frame -> arb_error high for exactly 1 cycle, aligned with that beat's arb_ob_wr; beat forwarded.
- frame_cnt0 preloaded near all-ones (force to 0xFFFFFFFE), forward 3 frames -> counter reads 0xFFFFFFFF and stays.
- rst_n asserted mid-frame on src0, then released with src1 backlogged -> all outputs 0 during reset; the first grant after release goes to src0 (last_src=1, credit=0).

Source files
------------

// File: rtl/cr_tlvp_ib_arb_if.sv
// rtl/cr_tlvp_ib_arb_if.sv - beat type and source/sink bus bundle for the TLVP input-buffer arbiter
//
// Package cr_tlvp_ib_arb_pkg:
//   axi4s_dp_bus_t : one datapath beat {tdata[31:0], tuser[1:0], tlast}.
//                    tuser[0] marks start-of-TLV-frame (sot).
// Interface cr_tlvp_ib_arb_if:
//   src0_empty/src0_ib/src0_rd : source 0 FIFO head and pop
//   src1_empty/src1_ib/src1_rd : source 1 FIFO head and pop
//   arb_ob_afull               : TLVP input FIFO almost-full
//   arb_ob_wr/arb_ob/arb_ob_src: write strobe, beat and source index
//   modport master : arbiter side
//   modport slave  : FIFO / environment side

package cr_tlvp_ib_arb_pkg;

    typedef struct packed {
        logic [31:0] tdata;
        logic [1:0]  tuser;
        logic        tlast;
    } axi4s_dp_bus_t;

endpackage

interface cr_tlvp_ib_arb_if;
    import cr_tlvp_ib_arb_pkg::*;

    logic          src0_empty;
    axi4s_dp_bus_t src0_ib;
    logic          src0_rd;
    logic          src1_empty;
    axi4s_dp_bus_t src1_ib;
    logic          src1_rd;
    logic          arb_ob_afull;
    logic          arb_ob_wr;
    axi4s_dp_bus_t arb_ob;
    logic          arb_ob_src;

    modport master (
        input  src0_empty, src0_ib, src1_empty, src1_ib, arb_ob_afull,
        output src0_rd, src1_rd, arb_ob_wr, arb_ob, arb_ob_src
    );

    modport slave (
        output src0_empty, src0_ib, src1_empty, src1_ib, arb_ob_afull,
        input  src0_rd, src1_rd, arb_ob_wr, arb_ob, arb_ob_src
    );

endinterface

// File: rtl/cr_tlvp_ib_arb.sv
// rtl/cr_tlvp_ib_arb.sv - frame-granular weighted round-robin merge of two sources into the TLVP input FIFO
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ib (master)    : both source FIFO heads/pops and the TLVP input FIFO write side
//   cfg_en[1:0]    : per-source enable, sampled only when choosing the next frame
//   cfg_weight0/1  : max consecutive frames per source (0 behaves as 1)
//   frame_cnt0/1   : saturating count of frames forwarded per source
//   arb_error      : one-cycle pulse, aligned with the offending beat's write
//
// A source owns the output from its first beat through tlast, so frames are
// never interleaved. Every frame is preceded by one ARB decision cycle.

module cr_tlvp_ib_arb #(
    parameter int CNT_W    = 32,
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cr_tlvp_ib_arb_if.master    ib,
    input  logic [1:0]          cfg_en,
    input  logic [WEIGHT_W-1:0] cfg_weight0,
    input  logic [WEIGHT_W-1:0] cfg_weight1,
    output logic [CNT_W-1:0]    frame_cnt0,
    output logic [CNT_W-1:0]    frame_cnt1,
    output logic                arb_error
);

    typedef enum logic {ARB, GRANT} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic                first_q, first_d;

    logic                cand0, cand1;
    logic                sel;
    logic [WEIGHT_W-1:0] wsel;
    logic                rd0, rd1;
    logic                pop;
    logic                pop_tlast;
    logic                pop_sot;

    assign ib.src0_rd = rd0;
    assign ib.src1_rd = rd1;

    assign pop_tlast = grant_q ? ib.src1_ib.tlast    : ib.src0_ib.tlast;
    assign pop_sot   = grant_q ? ib.src1_ib.tuser[0] : ib.src0_ib.tuser[0];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        credit_d = credit_q;
        first_d  = first_q;
        sel      = last_q;
        wsel     = '0;
        rd0      = 1'b0;
        rd1      = 1'b0;
        pop      = 1'b0;
        cand0    = cfg_en[0] & ~ib.src0_empty;
        cand1    = cfg_en[1] & ~ib.src1_empty;

        case (state_q)
            ARB: begin
                if (cand0 | cand1) begin
                    if (cand0 & cand1)
                        sel = (credit_q != '0) ? last_q : ~last_q;
                    else
                        sel = cand1;
                    wsel    = sel ? cfg_weight1 : cfg_weight0;
                    state_d = GRANT;
                    grant_d = sel;
                    first_d = 1'b1;
                    if (sel == last_q) begin
                        // A lone candidate can be re-granted with no credit
                        // left; hold at zero so it does not wrap into a long run.
                        credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
                    end else begin
                        credit_d = (wsel != '0) ? wsel - 1'b1 : '0;
                        last_d   = sel;
                    end
                end
            end
            GRANT: begin
                if (grant_q)
                    rd1 = ~ib.src1_empty & ~ib.arb_ob_afull;
                else
                    rd0 = ~ib.src0_empty & ~ib.arb_ob_afull;
                pop = rd0 | rd1;
                if (pop) begin
                    first_d = 1'b0;
                    if (pop_tlast)
                        state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            credit_q      <= '0;
            first_q       <= 1'b0;
            ib.arb_ob_wr  <= 1'b0;
            ib.arb_ob     <= '0;
            ib.arb_ob_src <= 1'b0;
            arb_error     <= 1'b0;
            frame_cnt0    <= '0;
            frame_cnt1    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            credit_q     <= credit_d;
            first_q      <= first_d;
            ib.arb_ob_wr <= pop;
            if (pop) begin
                ib.arb_ob     <= grant_q ? ib.src1_ib : ib.src0_ib;
                ib.arb_ob_src <= grant_q;
            end
            // Violation either way: sot where none is due, or no sot on a first beat.
            arb_error <= pop & (pop_sot ^ first_q);
            if (pop && pop_tlast && !grant_q && frame_cnt0 != {CNT_W{1'b1}})
                frame_cnt0 <= frame_cnt0 + 1'b1;
            if (pop && pop_tlast && grant_q && frame_cnt1 != {CNT_W{1'b1}})
                frame_cnt1 <= frame_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_cr_tlvp_ib_arb.sv
// tb/tb_cr_tlvp_ib_arb.sv - directed self-checking bench for cr_tlvp_ib_arb

module tb_cr_tlvp_ib_arb;
    import cr_tlvp_ib_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_en;
    logic [3:0]  w0, w1;
    logic [31:0] cnt0, cnt1;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cr_tlvp_ib_arb_if ifc ();

    cr_tlvp_ib_arb #(.CNT_W(32), .WEIGHT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ib          (ifc.master),
        .cfg_en      (cfg_en),
        .cfg_weight0 (w0),
        .cfg_weight1 (w1),
        .frame_cnt0  (cnt0),
        .frame_cnt1  (cnt1),
        .arb_error   (err)
    );

    axi4s_dp_bus_t q0[$];
    axi4s_dp_bus_t q1[$];
    logic          wr_src[$];
    logic [31:0]   wr_data[$];
    logic          wr_err[$];
    int            wr_cyc[$];
    int            rd0_cyc[$];
    int            rd1_cyc[$];
    int            stray = 0;
    int            cyc = 0;

    function automatic void push0(logic [31:0] d, logic [1:0] u, logic l);
        axi4s_dp_bus_t b;
        b.tdata = d; b.tuser = u; b.tlast = l;
        q0.push_back(b);
    endfunction

    function automatic void push1(logic [31:0] d, logic [1:0] u, logic l);
        axi4s_dp_bus_t b;
        b.tdata = d; b.tuser = u; b.tlast = l;
        q1.push_back(b);
    endfunction

    task automatic drive_srcs();
        ifc.src0_empty = (q0.size() == 0);
        ifc.src0_ib    = (q0.size() != 0) ? q0[0] : '0;
        ifc.src1_empty = (q1.size() == 0);
        ifc.src1_ib    = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic clear_logs();
        wr_src.delete(); wr_data.delete(); wr_err.delete(); wr_cyc.delete();
        rd0_cyc.delete(); rd1_cyc.delete();
        stray = 0;
    endtask

    // One clock: sample outputs at negedge, model the source FIFO pops after
    // the posedge, return at posedge+2 where tasks change inputs.
    task automatic step();
        logic s0, s1;
        @(negedge clk);
        cyc++;
        s0 = ifc.src0_rd;
        s1 = ifc.src1_rd;
        if (s0) rd0_cyc.push_back(cyc);
        if (s1) rd1_cyc.push_back(cyc);
        if (ifc.arb_ob_wr) begin
            wr_src.push_back(ifc.arb_ob_src);
            wr_data.push_back(ifc.arb_ob.tdata);
            wr_err.push_back(err);
            wr_cyc.push_back(cyc);
        end else if (err) begin
            stray++;
        end
        @(posedge clk);
        #1;
        if (s0 && q0.size() != 0) q0.delete(0);
        if (s1 && q1.size() != 0) q1.delete(0);
        drive_srcs();
        #1;
    endtask

    task automatic wait_wr(int n, int budget);
        int k = 0;
        while (wr_src.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (wr_src.size() < n) begin
            errors++;
            $display("FAIL wait_wr writes=%0d required=%0d", wr_src.size(), n);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        ifc.arb_ob_afull = 1'b0;
        drive_srcs();
        step(); step();
        rst_n = 1'b1;
        clear_logs();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_en = 2'b11; w0 = 4'd1; w1 = 4'd1;
        ifc.arb_ob_afull = 1'b0;
        push0(32'h5, 2'b01, 1'b1);
        drive_srcs();
        step(); step();
        checks += 8;
        if (ifc.arb_ob_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", ifc.arb_ob_wr); end
        if (ifc.arb_ob !== '0) begin errors++; $display("FAIL reset_ob got %h exp 0", ifc.arb_ob); end
        if (ifc.arb_ob_src !== 1'b0) begin errors++; $display("FAIL reset_src got %b exp 0", ifc.arb_ob_src); end
        if (cnt0 !== 32'd0) begin errors++; $display("FAIL reset_cnt0 got %h exp 0", cnt0); end
        if (cnt1 !== 32'd0) begin errors++; $display("FAIL reset_cnt1 got %h exp 0", cnt1); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        if (ifc.src0_rd !== 1'b0) begin errors++; $display("FAIL reset_rd0 got %b exp 0", ifc.src0_rd); end
        if (ifc.src1_rd !== 1'b0) begin errors++; $display("FAIL reset_rd1 got %b exp 0", ifc.src1_rd); end
    endtask

    task automatic test_single_src();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
        apply_reset();
        cfg_en = 2'b01; w0 = 4'd1; w1 = 4'd1;
        push0(32'hA0, 2'b01, 1'b0);
        push0(32'hA1, 2'b00, 1'b0);
        push0(32'hA2, 2'b10, 1'b1);
        wait_wr(3, 50);
        step(); step();
        checks++;
        if (wr_src.size() != 3) begin errors++; $display("FAIL single_wr_count got %0d exp 3", wr_src.size()); end
        if (wr_src.size() >= 3 && rd0_cyc.size() != 0) begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL single_data%0d got %h exp %h", i, wr_data[i], exp_d[i]); end
                if (wr_src[i] !== 1'b0) begin errors++; $display("FAIL single_src%0d got %b exp 0", i, wr_src[i]); end
            end
            checks += 2;
            if (wr_cyc[0] != rd0_cyc[0] + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", wr_cyc[0], rd0_cyc[0] + 1); end
            if (wr_cyc[2] != wr_cyc[0] + 2) begin errors++; $display("FAIL single_contig got %0d exp %0d", wr_cyc[2], wr_cyc[0] + 2); end
        end
        checks += 3;
        if (cnt0 !== 32'd1) begin errors++; $display("FAIL single_cnt0 got %0d exp 1", cnt0); end
        if (cnt1 !== 32'd0) begin errors++; $display("FAIL single_cnt1 got %0d exp 0", cnt1); end
        if ((wr_err.sum() with (int'(item))) + stray != 0) begin errors++; $display("FAIL single_err got %0d exp 0", (wr_err.sum() with (int'(item))) + stray); end
    endtask

    task automatic test_wrr();
        logic        exp_s [6];
        logic [31:0] exp_d [6];
        exp_s[0] = 0; exp_s[1] = 0; exp_s[2] = 1; exp_s[3] = 0; exp_s[4] = 0; exp_s[5] = 1;
        exp_d[0] = 32'h100; exp_d[1] = 32'h101; exp_d[2] = 32'h200;
        exp_d[3] = 32'h102; exp_d[4] = 32'h103; exp_d[5] = 32'h201;
        apply_reset();
        cfg_en = 2'b11; w0 = 4'd2; w1 = 4'd1;
        for (int i = 0; i < 6; i++) begin
            push0(32'h100 + i, 2'b01, 1'b1);
            push1(32'h200 + i, 2'b01, 1'b1);
        end
        wait_wr(6, 100);
        checks += 2;
        if (cnt0 !== 32'd4) begin errors++; $display("FAIL wrr_cnt0 got %0d exp 4", cnt0); end
        if (cnt1 !== 32'd2) begin errors++; $display("FAIL wrr_cnt1 got %0d exp 2", cnt1); end
        if (wr_src.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checks += 2;
                if (wr_src[i] !== exp_s[i]) begin errors++; $display("FAIL wrr_grant%0d got %b exp %b", i, wr_src[i], exp_s[i]); end
                if (wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL wrr_data%0d got %h exp %h", i, wr_data[i], exp_d[i]); end
            end
            checks++;
            if (wr_cyc[1] != wr_cyc[0] + 2) begin errors++; $display("FAIL wrr_bubble got %0d exp %0d", wr_cyc[1] - wr_cyc[0], 2); end
        end
    endtask

    task automatic test_afull();
        int n = 0;
        apply_reset();
        cfg_en = 2'b11; w0 = 4'd1; w1 = 4'd1;
        push1(32'hB0, 2'b01, 1'b0);
        push1(32'hB1, 2'b00, 1'b0);
        push1(32'hB2, 2'b00, 1'b0);
        push1(32'hB3, 2'b10, 1'b1);
        while (!ifc.src1_rd && n < 20) begin step(); n++; end
        checks++;
        if (!ifc.src1_rd) begin errors++; $display("FAIL afull_grant1 got %b exp 1", ifc.src1_rd); end
        step();
        push0(32'hC0, 2'b01, 1'b0);
        push0(32'hC1, 2'b00, 1'b0);
        push0(32'hC2, 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            ifc.arb_ob_afull = 1'b1;
            #1;
            checks += 2;
            if (ifc.src1_rd !== 1'b0) begin errors++; $display("FAIL afull_rd1_%0d got %b exp 0", i, ifc.src1_rd); end
            if (ifc.src0_rd !== 1'b0) begin errors++; $display("FAIL afull_rd0_%0d got %b exp 0", i, ifc.src0_rd); end
        end
        step();
        ifc.arb_ob_afull = 1'b0;
        wait_wr(7, 60);
        if (wr_src.size() >= 7 && rd0_cyc.size() != 0 && rd1_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (wr_src[i] !== 1'b1) begin errors++; $display("FAIL afull_src%0d got %b exp 1", i, wr_src[i]); end
                if (wr_data[i] !== 32'hB0 + i) begin errors++; $display("FAIL afull_data%0d got %h exp %h", i, wr_data[i], 32'hB0 + i); end
            end
            checks += 4;
            if (wr_cyc[1] != wr_cyc[0] + 6) begin errors++; $display("FAIL afull_stall got %0d exp 6", wr_cyc[1] - wr_cyc[0]); end
            if (wr_cyc[3] != wr_cyc[1] + 2) begin errors++; $display("FAIL afull_contig got %0d exp 2", wr_cyc[3] - wr_cyc[1]); end
            if (rd0_cyc[0] <= rd1_cyc[3]) begin errors++; $display("FAIL afull_no_interleave got %0d exp >%0d", rd0_cyc[0], rd1_cyc[3]); end
            if (wr_src[4] !== 1'b0) begin errors++; $display("FAIL afull_next_src got %b exp 0", wr_src[4]); end
        end
    endtask

    task automatic test_framing();
        apply_reset();
        cfg_en = 2'b01; w0 = 4'd1; w1 = 4'd1;
        push0(32'hD0, 2'b01, 1'b0);
        push0(32'hD1, 2'b01, 1'b0);
        push0(32'hD2, 2'b10, 1'b1);
        push0(32'hD3, 2'b00, 1'b1);
        wait_wr(4, 60);
        step(); step();
        if (wr_err.size() >= 4) begin
            checks += 6;
            if (wr_err[0] !== 1'b0) begin errors++; $display("FAIL frm_err0 got %b exp 0", wr_err[0]); end
            if (wr_err[1] !== 1'b1) begin errors++; $display("FAIL frm_err_midsot got %b exp 1", wr_err[1]); end
            if (wr_err[2] !== 1'b0) begin errors++; $display("FAIL frm_err2 got %b exp 0", wr_err[2]); end
            if (wr_err[3] !== 1'b1) begin errors++; $display("FAIL frm_err_nosot got %b exp 1", wr_err[3]); end
            if (wr_data[1] !== 32'hD1) begin errors++; $display("FAIL frm_fwd got %h exp D1", wr_data[1]); end
            if (stray != 0) begin errors++; $display("FAIL frm_stray got %0d exp 0", stray); end
        end
        checks++;
        if (cnt0 !== 32'd2) begin errors++; $display("FAIL frm_cnt0 got %0d exp 2", cnt0); end
    endtask

    task automatic test_saturate();
        apply_reset();
        cfg_en = 2'b01; w0 = 4'd1; w1 = 4'd1;
        force dut.frame_cnt0 = 32'hFFFF_FFFE;
        step();
        release dut.frame_cnt0;
        step();
        checks++;
        if (cnt0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got %h exp fffffffe", cnt0); end
        for (int i = 0; i < 3; i++) push0(32'hE0 + i, 2'b01, 1'b1);
        wait_wr(3, 60);
        step(); step();
        checks++;
        if (cnt0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_top got %h exp ffffffff", cnt0); end
        step(); step(); step();
        checks++;
        if (cnt0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp ffffffff", cnt0); end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        apply_reset();
        cfg_en = 2'b11; w0 = 4'd1; w1 = 4'd1;
        push0(32'hF0, 2'b01, 1'b0);
        push0(32'hF1, 2'b00, 1'b0);
        push0(32'hF2, 2'b10, 1'b1);
        while (!ifc.src0_rd && n < 20) begin step(); n++; end
        step(); step();
        rst_n = 1'b0;
        #1;
        checks += 8;
        if (ifc.arb_ob_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %b exp 0", ifc.arb_ob_wr); end
        if (ifc.arb_ob !== '0) begin errors++; $display("FAIL rstmid_ob got %h exp 0", ifc.arb_ob); end
        if (ifc.arb_ob_src !== 1'b0) begin errors++; $display("FAIL rstmid_src got %b exp 0", ifc.arb_ob_src); end
        if (cnt0 !== 32'd0) begin errors++; $display("FAIL rstmid_cnt0 got %h exp 0", cnt0); end
        if (cnt1 !== 32'd0) begin errors++; $display("FAIL rstmid_cnt1 got %h exp 0", cnt1); end
        if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", err); end
        if (ifc.src0_rd !== 1'b0) begin errors++; $display("FAIL rstmid_rd0 got %b exp 0", ifc.src0_rd); end
        if (ifc.src1_rd !== 1'b0) begin errors++; $display("FAIL rstmid_rd1 got %b exp 0", ifc.src1_rd); end
        q0.delete(); q1.delete();
        push1(32'h300, 2'b01, 1'b1);
        push1(32'h301, 2'b01, 1'b1);
        push0(32'h400, 2'b01, 1'b1);
        step(); step();
        rst_n = 1'b1;
        clear_logs();
        n = 0;
        while (!(ifc.src0_rd || ifc.src1_rd) && n < 20) begin step(); n++; end
        checks += 2;
        if (ifc.src0_rd !== 1'b1) begin errors++; $display("FAIL rstmid_first_rd0 got %b exp 1", ifc.src0_rd); end
        if (ifc.src1_rd !== 1'b0) begin errors++; $display("FAIL rstmid_first_rd1 got %b exp 0", ifc.src1_rd); end
        wait_wr(1, 20);
        if (wr_src.size() >= 1) begin
            checks += 2;
            if (wr_src[0] !== 1'b0) begin errors++; $display("FAIL rstmid_first_src got %b exp 0", wr_src[0]); end
            if (wr_data[0] !== 32'h400) begin errors++; $display("FAIL rstmid_first_data got %h exp 400", wr_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_src();
        test_wrr();
        test_afull();
        test_framing();
        test_saturate();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
